// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: registered RV32I instruction-decode stage.
// Takes one instruction and its PC per valid/ready handshake. The instruction
// is split into rs1/rs2, a sign-extended immediate and the control_bus_t
// bundle. The result is held in an output register that supports backpressure
// and flush.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid/o_ready       fetch-side handshake (o_ready is combinational)
//   i_instr, i_pc         instruction word and its PC
//   i_flush               drops the held bundle and any incoming instruction
//   o_valid/i_ready       execute-side handshake
//   o_ctrl                control_bus_t, 18 bits
//   o_rs1, o_rs2, o_imm   source register indices, immediate
//   o_pc                  PC of the held bundle
//   o_branch/o_jal/o_jalr control-transfer flags
//   o_illegal             undecodable instruction

package riscv_decode_stage_pkg;

   typedef struct packed {
      logic       alu_src1;      // 1 = PC
      logic       alu_src2;      // 1 = immediate
      logic [2:0] alu_op;
      logic       arith_logic;
      logic [4:0] rd;
      logic       dmem_rd;
      logic       dmem_wr;
      logic [2:0] ld_st_funct3;
      logic       rf_wr;
      logic       wb_to_rf;      // 1 = memory
   } control_bus_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_RR     = 7'b0110011;

   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

endpackage

module riscv_decode_stage
   import riscv_decode_stage_pkg::*;
#(
   parameter int unsigned NB_WORD    = 32,
   parameter int unsigned NB_OPERAND = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [NB_WORD-1:0]    i_instr,
   input  logic [NB_WORD-1:0]    i_pc,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [17:0]           o_ctrl,
   output logic [NB_OPERAND-1:0] o_rs1,
   output logic [NB_OPERAND-1:0] o_rs2,
   output logic [NB_WORD-1:0]    o_imm,
   output logic [NB_WORD-1:0]    o_pc,
   output logic                  o_branch,
   output logic                  o_jal,
   output logic                  o_jalr,
   output logic                  o_illegal
);

   localparam int unsigned NB_CTRL = $bits(control_bus_t);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   logic [NB_WORD-1:0] imm_i;
   logic [NB_WORD-1:0] imm_s;
   logic [NB_WORD-1:0] imm_b;
   logic [NB_WORD-1:0] imm_u;
   logic [NB_WORD-1:0] imm_j;

   control_bus_t          d_ctrl;
   logic [NB_OPERAND-1:0] d_rs1;
   logic [NB_OPERAND-1:0] d_rs2;
   logic [NB_WORD-1:0]    d_imm;
   logic                  d_branch;
   logic                  d_jal;
   logic                  d_jalr;
   logic                  d_illegal;

   logic load_en;

   assign opcode = i_instr[6:0];
   assign funct3 = i_instr[14:12];
   assign funct7 = i_instr[31:25];

   // Immediate formats
   assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign imm_u = {i_instr[31:12], 12'b0};
   assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   // Combinational decode of the incoming instruction
   always_comb begin
      d_ctrl    = '0;
      d_ctrl.rd = i_instr[11:7];
      d_rs1     = i_instr[19:15];
      d_rs2     = i_instr[24:20];
      d_imm     = '0;
      d_branch  = 1'b0;
      d_jal     = 1'b0;
      d_jalr    = 1'b0;
      d_illegal = 1'b0;

      case (opcode)
         OP_LUI: begin
            d_rs1           = '0;
            d_ctrl.alu_src2 = 1'b1;
            d_ctrl.rf_wr    = 1'b1;
            d_imm           = imm_u;
         end
         OP_AUIPC: begin
            d_ctrl.alu_src1 = 1'b1;
            d_ctrl.alu_src2 = 1'b1;
            d_ctrl.rf_wr    = 1'b1;
            d_imm           = imm_u;
         end
         OP_JAL: begin
            d_ctrl.alu_src1 = 1'b1;
            d_ctrl.alu_src2 = 1'b1;
            d_ctrl.rf_wr    = 1'b1;
            d_imm           = imm_j;
            d_jal           = 1'b1;
         end
         OP_JALR: begin
            d_ctrl.alu_src2 = 1'b1;
            d_ctrl.rf_wr    = 1'b1;
            d_imm           = imm_i;
            d_jalr          = 1'b1;
            d_illegal       = (funct3 != 3'b000);
         end
         OP_BRANCH: begin
            d_ctrl.alu_op = funct3;
            d_ctrl.rd     = '0;
            d_imm         = imm_b;
            d_branch      = 1'b1;
            d_illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OP_LOAD: begin
            d_ctrl.alu_src2     = 1'b1;
            d_ctrl.dmem_rd      = 1'b1;
            d_ctrl.ld_st_funct3 = funct3;
            d_ctrl.rf_wr        = 1'b1;
            d_ctrl.wb_to_rf     = 1'b1;
            d_imm               = imm_i;
            d_illegal           = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OP_STORE: begin
            d_ctrl.alu_src2     = 1'b1;
            d_ctrl.dmem_wr      = 1'b1;
            d_ctrl.ld_st_funct3 = funct3;
            d_ctrl.rd           = '0;
            d_imm               = imm_s;
            d_illegal           = funct3[2] || (funct3 == 3'b011);
         end
         OP_IMM: begin
            d_ctrl.alu_src2 = 1'b1;
            d_ctrl.alu_op   = funct3;
            d_ctrl.rf_wr    = 1'b1;
            d_imm           = imm_i;
            // Shift-immediates reuse imm[11:5] as funct7
            if (funct3 == 3'b001) begin
               d_illegal = (funct7 != F7_ZERO);
            end else if (funct3 == 3'b101) begin
               d_illegal          = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
               d_ctrl.arith_logic = (funct7 == F7_ALT);
            end
         end
         OP_RR: begin
            d_ctrl.alu_op = funct3;
            d_ctrl.rf_wr  = 1'b1;
            if (funct7 == F7_ALT) begin
               d_ctrl.arith_logic = 1'b1;
               d_illegal          = (funct3 != 3'b000) && (funct3 != 3'b101);
            end else begin
               d_illegal = (funct7 != F7_ZERO);
            end
         end
         default: begin
            d_illegal = 1'b1;
         end
      endcase

      // Writes to x0 are suppressed; loads still touch memory
      if (d_ctrl.rd == '0) begin
         d_ctrl.rf_wr = 1'b0;
      end

      if (d_illegal) begin
         d_ctrl   = '0;
         d_imm    = '0;
         d_branch = 1'b0;
         d_jal    = 1'b0;
         d_jalr   = 1'b0;
      end
   end

   assign o_ready = !o_valid || i_ready;
   assign load_en = i_valid && o_ready;

   // Output pipeline register; flush beats load and stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid   <= 1'b0;
         o_ctrl    <= '0;
         o_rs1     <= '0;
         o_rs2     <= '0;
         o_imm     <= '0;
         o_pc      <= '0;
         o_branch  <= 1'b0;
         o_jal     <= 1'b0;
         o_jalr    <= 1'b0;
         o_illegal <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (load_en) begin
         o_valid   <= 1'b1;
         o_ctrl    <= NB_CTRL'(d_ctrl);
         o_rs1     <= d_rs1;
         o_rs2     <= d_rs2;
         o_imm     <= d_imm;
         o_pc      <= i_pc;
         o_branch  <= d_branch;
         o_jal     <= d_jal;
         o_jalr    <= d_jalr;
         o_illegal <= d_illegal;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Testbench for riscv_decode_stage: scoreboard of reference-decoded bundles,
// directed vectors, backpressure, flush, asynchronous reset and a random stream.
module tb_riscv_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_instr;
   logic [31:0] i_pc;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [17:0] o_ctrl;
   logic [4:0]  o_rs1;
   logic [4:0]  o_rs2;
   logic [31:0] o_imm;
   logic [31:0] o_pc;
   logic        o_branch;
   logic        o_jal;
   logic        o_jalr;
   logic        o_illegal;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [95:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   logic        stalled = 1'b0;
   logic [95:0] held;
   logic        rnd_done;

   riscv_decode_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_instr   (i_instr),
      .i_pc      (i_pc),
      .i_flush   (i_flush),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_ctrl    (o_ctrl),
      .o_rs1     (o_rs1),
      .o_rs2     (o_rs2),
      .o_imm     (o_imm),
      .o_pc      (o_pc),
      .o_branch  (o_branch),
      .o_jal     (o_jal),
      .o_jalr    (o_jalr),
      .o_illegal (o_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] obs();
      return {o_ctrl, o_rs1, o_rs2, o_imm, o_branch, o_jal, o_jalr, o_illegal, o_pc};
   endfunction

   // Reference decoder: {ctrl, rs1, rs2, imm, branch, jal, jalr, illegal, pc}
   function automatic logic [95:0] model(input logic [31:0] ins, input logic [31:0] pc);
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd, rs1, rs2;
      logic        s1, s2, al, dr, dw, rw, wb, br, jl, jr, ill;
      logic [2:0]  aop, lsf;
      logic [31:0] imm, i_imm, s_imm, b_imm, u_imm, j_imm;
      f3 = ins[14:12];
      f7 = ins[31:25];
      rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
      {s1, s2, al, dr, dw, rw, wb, br, jl, jr, ill} = '0;
      aop = 3'd0; lsf = 3'd0; imm = 32'd0;
      i_imm = 32'($signed(ins) >>> 20);
      s_imm = {i_imm[31:5], ins[11:7]};
      b_imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      u_imm = {ins[31:12], 12'h000};
      j_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      case (ins[6:0])
         7'h37: begin rs1 = 5'd0; s2 = 1; rw = 1; imm = u_imm; end
         7'h17: begin s1 = 1; s2 = 1; rw = 1; imm = u_imm; end
         7'h6F: begin s1 = 1; s2 = 1; rw = 1; jl = 1; imm = j_imm; end
         7'h67: begin s2 = 1; rw = 1; jr = 1; imm = i_imm; ill = (f3 != 0); end
         7'h63: begin aop = f3; rd = 5'd0; br = 1; imm = b_imm; ill = (f3 == 2 || f3 == 3); end
         7'h03: begin s2 = 1; dr = 1; lsf = f3; rw = 1; wb = 1; imm = i_imm;
                      ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); end
         7'h23: begin s2 = 1; dw = 1; lsf = f3; rd = 5'd0; imm = s_imm; ill = (f3 > 2); end
         7'h13: begin s2 = 1; aop = f3; rw = 1; imm = i_imm;
                      ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
                      al  = (f3 == 5 && f7 == 7'h20); end
         7'h33: begin aop = f3; rw = 1;
                      ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
                      al  = (f7 == 7'h20); end
         default: ill = 1;
      endcase
      if (rd == 0) rw = 0;
      if (ill) begin
         {s1, s2, al, dr, dw, rw, wb, br, jl, jr} = '0;
         aop = 0; lsf = 0; rd = 0; imm = 0;
      end
      return {s1, s2, aop, al, rd, dr, dw, lsf, rw, wb, rs1, rs2, imm, br, jl, jr, ill, pc};
   endfunction

   // Hand-derived expectations for the named vectors
   task automatic directed(input logic [31:0] ins);
      case (ins)
         32'hFFF00093: begin
            chk("addi_ctrl", o_ctrl, 18'h10082);
            chk("addi_imm", o_imm, 32'hFFFFFFFF);
            chk("addi_rs1", o_rs1, 5'd0);
         end
         32'h402081B3: begin
            chk("sub_ctrl", o_ctrl, 18'h01182);
            chk("sub_rs", {o_rs1, o_rs2}, {5'd1, 5'd2});
         end
         32'hFE000EE3: begin
            chk("beq_flags", {o_branch, o_jal, o_jalr}, 3'b100);
            chk("beq_imm", o_imm, 32'hFFFFFFFC);
            chk("beq_ctrl", o_ctrl, 18'h0);
         end
         32'h0020A423: begin
            chk("sw_ctrl", o_ctrl, 18'h10028);
            chk("sw_imm", o_imm, 32'd8);
         end
         32'h00000000: begin
            chk("zero_illegal", o_illegal, 1'b1);
            chk("zero_ctrl", o_ctrl, 18'h0);
         end
         32'h00000013: chk("nop_ctrl", o_ctrl, 18'h10000);
         default: ;
      endcase
   endtask

   // Monitor and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      sb_t e;
      if (!rst_n) begin
         sb_q.delete();
         stalled = 1'b0;
      end else begin
         chk("valid", o_valid, sb_q.size() != 0);
         chk("ready", o_ready, !o_valid || i_ready);
         if (stalled && o_valid) chk("stall_hold", obs(), held);
         stalled = 1'b0;
         if (i_flush) begin
            sb_q.delete();
         end else begin
            if (o_valid && sb_q.size() != 0) begin
               if (i_ready) begin
                  e = sb_q.pop_front();
                  chk("bundle", obs(), e.exp);
                  directed(e.instr);
               end else begin
                  stalled = 1'b1;
                  held    = obs();
               end
            end
            if (i_valid && o_ready) begin
               e.instr = i_instr;
               e.exp   = model(i_instr, i_pc);
               sb_q.push_back(e);
            end
         end
      end
   end

   // Present one instruction until accepted; returns at posedge+1
   task automatic send(input logic [31:0] ins, input logic [31:0] pc);
      logic acc;
      int   n = 0;
      i_valid = 1'b1;
      i_instr = ins;
      i_pc    = pc;
      forever begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         n++;
         if (n > 50) begin
            chk("accept_timeout", 1'b0, 1'b1);
            break;
         end
      end
      i_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  ops [9];
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         default: ;
      endcase
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [31:0] dir_vec [11];

   initial begin
      dir_vec = '{32'hFFF00093, 32'h402081B3, 32'hFE000EE3, 32'h0020A423, 32'h00000000,
                  32'h00000013, 32'h004000EF, 32'h00008067, 32'h123450B7, 32'h00001097,
                  32'h0040A103};
      rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0; i_flush = 1'b0; i_ready = 1'b1;
      rnd_done = 1'b0;
      #12;
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_outputs", obs(), 96'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("post_rst_ready", o_ready, 1'b1);

      // Directed vectors, back to back
      for (int k = 0; k < 11; k++) send(dir_vec[k], 32'h1000 + 32'(k * 4));
      idle(3);

      // Backpressure: stall two cycles once the first bundle is valid
      fork
         begin
            send(32'h00500093, 32'h2000);
            send(32'h00208133, 32'h2004);
            send(32'h0000A183, 32'h2008);
         end
         begin
            int n = 0;
            while (!o_valid && n < 20) begin @(posedge clk); #1; n++; end
            i_ready = 1'b0;
            idle(2);
            i_ready = 1'b1;
         end
      join
      idle(3);
      chk("bp_drain", sb_q.size(), 0);

      // Flush while stalled, with a concurrent input that must be dropped
      i_ready = 1'b0;
      send(32'h00100093, 32'h3000);
      chk("pre_flush_valid", o_valid, 1'b1);
      i_flush = 1'b1; i_valid = 1'b1; i_instr = 32'h00200113; i_pc = 32'h3004;
      @(posedge clk); #1;
      chk("flush_valid", o_valid, 1'b0);
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      idle(2);

      // Random stream with random backpressure
      fork
         begin
            for (int k = 0; k < 300; k++) send(rand_instr(), 32'h4000 + 32'(k * 4));
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               if (!rnd_done) i_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      i_ready = 1'b1;
      idle(3);
      chk("rnd_drain", sb_q.size(), 0);

      // Asynchronous reset mid-stream
      i_ready = 1'b0;
      send(32'h00300193, 32'h5000);
      chk("pre_rst_valid", o_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", o_valid, 1'b0);
      chk("async_rst_ready", o_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1; i_ready = 1'b1;
      send(32'h00400213, 32'h6000);
      idle(3);
      chk("final_drain", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
